// File: rtl/tmr_time_voter.sv
// rtl/tmr_time_voter.sv - TMR majority voter for MTIME/EXT_RESETN with fault tracking
module tmr_time_voter #(
    parameter int WIDTH   = 64,
    parameter int PERSIST = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] time_a,
    input  logic [WIDTH-1:0] time_b,
    input  logic [WIDTH-1:0] time_c,
    input  logic             resetn_a,
    input  logic             resetn_b,
    input  logic             resetn_c,
    input  logic             fault_clear,
    output logic [WIDTH-1:0] voted_time_count,
    output logic             voted_resetn,
    output logic             disagreement,
    output logic [2:0]       fault_flags,
    output logic             multi_fault,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [7:0]       PERSIST_C = 8'(PERSIST);
    localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};

    logic [WIDTH:0]       vec_a, vec_b, vec_c, vec_maj;
    logic [2:0]           mis;
    logic                 any_mis;
    logic                 multi_d;
    logic [2:0][7:0]      pc_d, pc_q;
    logic [2:0]           flags_d, flags_q;
    logic [CNT_W-1:0]     err_d, err_q;
    logic [WIDTH-1:0]     time_d, time_q;
    logic                 rstn_d, rstn_q;
    logic                 dis_d, dis_q;
    logic                 multi_q;

    // resetn rides as the LSB so mismatch and pair checks cover the full vector
    assign vec_a   = {time_a, resetn_a};
    assign vec_b   = {time_b, resetn_b};
    assign vec_c   = {time_c, resetn_c};
    assign vec_maj = (vec_a & vec_b) | (vec_a & vec_c) | (vec_b & vec_c);

    always_comb begin
        time_d  = vec_maj[WIDTH:1];
        rstn_d  = vec_maj[0];
        mis[0]  = (vec_a != vec_maj);
        mis[1]  = (vec_b != vec_maj);
        mis[2]  = (vec_c != vec_maj);
        any_mis = |mis;
        dis_d   = any_mis;
        multi_d = (vec_a != vec_b) && (vec_a != vec_c) && (vec_b != vec_c);
    end

    always_comb begin
        pc_d    = pc_q;
        flags_d = flags_q;
        err_d   = err_q;
        if (fault_clear) begin
            pc_d    = '0;
            flags_d = '0;
            err_d   = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!mis[i]) begin
                    pc_d[i] = 8'd0;
                end else if (pc_q[i] < PERSIST_C) begin
                    pc_d[i] = pc_q[i] + 8'd1;
                end
                if (mis[i] && (pc_d[i] == PERSIST_C)) begin
                    flags_d[i] = 1'b1;
                end
            end
            if (any_mis && (err_q != ERR_MAX)) begin
                err_d = err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q  <= '0;
            rstn_q  <= 1'b0;
            dis_q   <= 1'b0;
            multi_q <= 1'b0;
            pc_q    <= '0;
            flags_q <= '0;
            err_q   <= '0;
        end else begin
            time_q  <= time_d;
            rstn_q  <= rstn_d;
            dis_q   <= dis_d;
            multi_q <= multi_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign voted_time_count = time_q;
    assign voted_resetn     = rstn_q;
    assign disagreement     = dis_q;
    assign multi_fault      = multi_q;
    assign fault_flags      = flags_q;
    assign err_count        = err_q;

endmodule

// File: tb/tb_tmr_time_voter.sv
// tb/tb_tmr_time_voter.sv - directed self-checking bench for tmr_time_voter
module tb_tmr_time_voter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] time_a, time_b, time_c;
    logic        resetn_a, resetn_b, resetn_c;
    logic        fault_clear;
    logic [63:0] voted_time_count;
    logic        voted_resetn;
    logic        disagreement;
    logic [2:0]  fault_flags;
    logic        multi_fault;
    logic [3:0]  err_count;

    int checks = 0;
    int fails  = 0;
    logic [63:0] t;

    always #5 clk = ~clk;

    tmr_time_voter #(.WIDTH(64), .PERSIST(4), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .time_a           (time_a),
        .time_b           (time_b),
        .time_c           (time_c),
        .resetn_a         (resetn_a),
        .resetn_b         (resetn_b),
        .resetn_c         (resetn_c),
        .fault_clear      (fault_clear),
        .voted_time_count (voted_time_count),
        .voted_resetn     (voted_resetn),
        .disagreement     (disagreement),
        .fault_flags      (fault_flags),
        .multi_fault      (multi_fault),
        .err_count        (err_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic [63:0] v);
        time_a = v; time_b = v; time_c = v;
        resetn_a = 1'b1; resetn_b = 1'b1; resetn_c = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        fault_clear = 1'b0;
        t = 64'h0000_0001_2345_6789;
        drive_all(t);
        #12;
        check("rst_time", voted_time_count, 64'h0);
        check("rst_resetn", {63'h0, voted_resetn}, 64'h0);
        check("rst_flags", {61'h0, fault_flags}, 64'h0);
        check("rst_err", {60'h0, err_count}, 64'h0);
        #2 rst_n = 1'b1;

        // all equal, incrementing
        for (int k = 0; k < 3; k++) begin
            drive_all(t + 64'(k));
            tick();
            check("eq_time", voted_time_count, t + 64'(k));
            check("eq_resetn", {63'h0, voted_resetn}, 64'h1);
            check("eq_dis", {63'h0, disagreement}, 64'h0);
            check("eq_flags", {61'h0, fault_flags}, 64'h0);
            check("eq_err", {60'h0, err_count}, 64'h0);
        end

        // single-cycle upset on core B bit 30
        t = 64'h0000_0001_2345_6800;
        drive_all(t);
        time_b = t ^ (64'h1 << 30);
        tick();
        check("upset_time", voted_time_count, t);
        check("upset_dis", {63'h0, disagreement}, 64'h1);
        check("upset_err", {60'h0, err_count}, 64'h1);
        check("upset_flags", {61'h0, fault_flags}, 64'h0);
        drive_all(t + 64'h1);
        tick();
        check("upset_dis_end", {63'h0, disagreement}, 64'h0);
        check("upset_err_hold", {60'h0, err_count}, 64'h1);

        // clear, then core C wrong for 4 cycles
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("clr_err", {60'h0, err_count}, 64'h0);
        for (int k = 1; k <= 4; k++) begin
            drive_all(t + 64'(k));
            time_c = (t + 64'(k)) ^ 64'hFF;
            tick();
            check("c_flags", {61'h0, fault_flags}, (k == 4) ? 64'h4 : 64'h0);
            check("c_err", {60'h0, err_count}, 64'(k));
        end
        drive_all(t + 64'h10);
        tick();
        check("c_flag_sticky", {61'h0, fault_flags}, 64'h4);
        check("c_dis_end", {63'h0, disagreement}, 64'h0);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("c_clr_flags", {61'h0, fault_flags}, 64'h0);
        check("c_clr_err", {60'h0, err_count}, 64'h0);

        // three-way disagreement
        for (int k = 1; k <= 4; k++) begin
            time_a = 64'h0000_0001_2345_670F;
            time_b = 64'h0000_0001_2345_6733;
            time_c = 64'h0000_0001_2345_6755;
            tick();
            check("mf_time", voted_time_count, 64'h0000_0001_2345_6717);
            check("mf_multi", {63'h0, multi_fault}, 64'h1);
            check("mf_flags", {61'h0, fault_flags}, (k == 4) ? 64'h7 : 64'h0);
        end
        check("mf_err", {60'h0, err_count}, 64'h4);
        drive_all(t);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("mf_clear_multi", {63'h0, multi_fault}, 64'h0);
        check("mf_clear_flags", {61'h0, fault_flags}, 64'h0);

        // clear coincides with pc_a reaching PERSIST
        for (int k = 1; k <= 4; k++) begin
            drive_all(t);
            time_a = t ^ 64'h1;
            fault_clear = (k == 4);
            tick();
        end
        fault_clear = 1'b0;
        check("pri_flags", {61'h0, fault_flags}, 64'h0);
        check("pri_err", {60'h0, err_count}, 64'h0);
        tick();
        check("pri_restart_flags", {61'h0, fault_flags}, 64'h0);
        check("pri_restart_err", {60'h0, err_count}, 64'h1);
        tick();
        tick();
        tick();
        check("pri_refault", {61'h0, fault_flags}, 64'h1);

        // continuous resetn mismatch on B: counter saturates
        drive_all(t);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        resetn_b = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) check("sat_15", {60'h0, err_count}, 64'hF);
        end
        check("sat_20", {60'h0, err_count}, 64'hF);
        check("sat_resetn", {63'h0, voted_resetn}, 64'h1);
        check("sat_flags", {61'h0, fault_flags}, 64'h2);
        check("sat_dis", {63'h0, disagreement}, 64'h1);

        // asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        check("arst_time", voted_time_count, 64'h0);
        check("arst_resetn", {63'h0, voted_resetn}, 64'h0);
        check("arst_dis", {63'h0, disagreement}, 64'h0);
        check("arst_flags", {61'h0, fault_flags}, 64'h0);
        check("arst_err", {60'h0, err_count}, 64'h0);
        #3 rst_n = 1'b1;
        drive_all(t + 64'h5);
        tick();
        check("post_rst_time", voted_time_count, t + 64'h5);
        check("post_rst_resetn", {63'h0, voted_resetn}, 64'h1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
